// File: rtl/lab4_pkg.sv
// rtl/lab4_pkg.sv - shared types and constants for the lab 4 task sequencer
package lab4_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;

    // Shown on the HEX display when the watchdog gives up on an engine
    localparam logic [7:0] ERR_DISP = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        HOLD,
        ERR
    } seq_state_t;

    typedef enum logic {
        MODE_BITCOUNT = 1'b0,
        MODE_SEARCH   = 1'b1
    } mode_t;

    function automatic logic [7:0] search_disp(input logic found, input logic [7:0] addr_ext);
        return found ? addr_ext : 8'h00;
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// rtl/key_sync_edge.sv - synchronizes an active-low key and pulses once per press
module key_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;

    // All flops reset to the released level so leaving reset never looks like a press
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign fall = prev & ~sync2;

endmodule

// File: rtl/task_sequencer.sv
// rtl/task_sequencer.sv - launches bit-count or binary-search engine per key press; watchdog under TASK_SEQ_TIMEOUT_EN
module task_sequencer
    import lab4_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_n,
    input  logic              mode,
    input  logic [DATA_W-1:0] operand,
    output logic              bc_start,
    output logic [DATA_W-1:0] bc_data,
    input  logic              bc_done,
    input  logic [3:0]        bc_result,
    output logic              bs_start,
    output logic [DATA_W-1:0] bs_target,
    input  logic              bs_done,
    input  logic              bs_found,
    input  logic [ADDR_W-1:0] bs_addr,
    output logic              busy,
    output logic              result_valid,
    output logic              timeout_err,
    output logic              disp_mode,
    output logic [7:0]        disp_value,
    output logic              disp_found
);

    seq_state_t state;
    logic       req;
    logic       can_launch;
    logic       sel_done;

    key_sync_edge u_start_key (
        .clk   (clk),
        .reset (reset),
        .key_n (start_n),
        .fall  (req)
    );

`ifdef TASK_SEQ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [WD_W-1:0] wdog;
    logic            timeout_err_r;

    assign timeout_err = timeout_err_r;
    assign can_launch  = req && (state == IDLE || state == HOLD || state == ERR);
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT);
    assign timeout_err    = 1'b0;
    assign can_launch     = req && (state == IDLE || state == HOLD);
`endif

    // Only the engine chosen at launch may end the wait
    assign sel_done = (mode_t'(disp_mode) == MODE_SEARCH) ? bs_done : bc_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bc_start      <= 1'b0;
            bs_start      <= 1'b0;
            bc_data       <= '0;
            bs_target     <= '0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            disp_mode     <= 1'b0;
            disp_value    <= 8'h00;
            disp_found    <= 1'b0;
`ifdef TASK_SEQ_TIMEOUT_EN
            wdog          <= '0;
            timeout_err_r <= 1'b0;
`endif
        end else begin
            bc_start <= 1'b0;
            bs_start <= 1'b0;
            if (can_launch) begin
                state        <= LAUNCH;
                busy         <= 1'b1;
                result_valid <= 1'b0;
                disp_mode    <= mode;
                bc_data      <= operand;
                bs_target    <= operand;
                bc_start     <= (mode_t'(mode) == MODE_BITCOUNT);
                bs_start     <= (mode_t'(mode) == MODE_SEARCH);
`ifdef TASK_SEQ_TIMEOUT_EN
                timeout_err_r <= 1'b0;
`endif
            end else begin
                case (state)
                    LAUNCH: begin
                        state <= WAIT;
`ifdef TASK_SEQ_TIMEOUT_EN
                        wdog  <= '0;
`endif
                    end
                    WAIT: begin
                        // done is checked first so it beats a same-cycle terminal count
                        if (sel_done) begin
                            state        <= HOLD;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                            if (mode_t'(disp_mode) == MODE_SEARCH) begin
                                disp_value <= search_disp(bs_found, 8'(bs_addr));
                                disp_found <= bs_found;
                            end else begin
                                disp_value <= {4'b0000, bc_result};
                                disp_found <= 1'b0;
                            end
`ifdef TASK_SEQ_TIMEOUT_EN
                        end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                            state         <= ERR;
                            busy          <= 1'b0;
                            timeout_err_r <= 1'b1;
                            disp_value    <= ERR_DISP;
                            disp_found    <= 1'b0;
                        end else begin
                            wdog <= wdog + 1'b1;
`endif
                        end
                    end
                    IDLE, HOLD: state <= state;
`ifdef TASK_SEQ_TIMEOUT_EN
                    ERR:        state <= ERR;
`endif
                    default:    state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_task_sequencer.sv
// tb/tb_task_sequencer.sv - scoreboard bench for task_sequencer with behavioural engines
module tb_task_sequencer;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start_n = 1'b1;
    logic              mode = 1'b0;
    logic [DATA_W-1:0] operand = '0;
    logic              bc_start, bs_start;
    logic [DATA_W-1:0] bc_data, bs_target;
    logic              bc_done, bs_done;
    logic [3:0]        bc_result;
    logic              bs_found;
    logic [ADDR_W-1:0] bs_addr;
    logic              busy, result_valid, timeout_err, disp_mode, disp_found;
    logic [7:0]        disp_value;

    task_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start_n(start_n), .mode(mode), .operand(operand),
        .bc_start(bc_start), .bc_data(bc_data), .bc_done(bc_done), .bc_result(bc_result),
        .bs_start(bs_start), .bs_target(bs_target), .bs_done(bs_done), .bs_found(bs_found),
        .bs_addr(bs_addr), .busy(busy), .result_valid(result_valid), .timeout_err(timeout_err),
        .disp_mode(disp_mode), .disp_value(disp_value), .disp_found(disp_found)
    );

    always #5 clk = ~clk;

    // Behavioural engines
    int          eng_lat = 8;
    logic        hang = 1'b0;
    logic        found_cfg = 1'b1;
    logic        force_done = 1'b0;
    logic        bc_done_m, bc_act, bs_done_m, bs_act;
    int          bc_cnt, bs_cnt;
    logic [3:0]  bc_pend;
    logic [ADDR_W-1:0] bs_pend;

    assign bc_done = bc_done_m | force_done;
    assign bs_done = bs_done_m | force_done;

    always @(posedge clk) begin
        if (reset) begin
            bc_done_m <= 1'b0; bc_act <= 1'b0; bc_cnt <= 0; bc_result <= 4'd0; bc_pend <= 4'd0;
        end else if (bc_start) begin
            bc_done_m <= 1'b0; bc_act <= 1'b1; bc_cnt <= 0; bc_pend <= 4'($countones(bc_data));
        end else if (bc_act && !hang) begin
            if (bc_cnt >= eng_lat - 1) begin
                bc_done_m <= 1'b1; bc_act <= 1'b0; bc_result <= bc_pend;
            end else bc_cnt <= bc_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            bs_done_m <= 1'b0; bs_act <= 1'b0; bs_cnt <= 0; bs_found <= 1'b0; bs_addr <= '0; bs_pend <= '0;
        end else if (bs_start) begin
            bs_done_m <= 1'b0; bs_act <= 1'b1; bs_cnt <= 0; bs_pend <= bs_target[ADDR_W-1:0];
        end else if (bs_act && !hang) begin
            if (bs_cnt >= eng_lat - 1) begin
                bs_done_m <= 1'b1; bs_act <= 1'b0; bs_found <= found_cfg; bs_addr <= bs_pend;
            end else bs_cnt <= bs_cnt + 1;
        end
    end

    int bc_starts = 0;
    int bs_starts = 0;
    always @(posedge clk) begin
        if (bc_start) bc_starts++;
        if (bs_start) bs_starts++;
    end

    typedef struct {
        logic [7:0] value;
        logic       found;
        logic       mode;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] v, input logic f, input logic m);
        exp_t e;
        e.value = v; e.found = f; e.mode = m;
        sb.push_back(e);
    endtask

    task automatic press();
        start_n = 1'b0;
        repeat (3) step();
        start_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        int n = 0;
        while (!result_valid && n < 200) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(result_valid), 32'd1);
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_value"}, 32'(disp_value), 32'(e.value));
            check({tag, "_found"}, 32'(disp_found), 32'(e.found));
            check({tag, "_mode"}, 32'(disp_mode), 32'(e.mode));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bc_start"}, 32'(bc_start), 32'd0);
        check({tag, "_bs_start"}, 32'(bs_start), 32'd0);
        check({tag, "_bc_data"}, 32'(bc_data), 32'd0);
        check({tag, "_bs_target"}, 32'(bs_target), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rvalid"}, 32'(result_valid), 32'd0);
        check({tag, "_terr"}, 32'(timeout_err), 32'd0);
        check({tag, "_dmode"}, 32'(disp_mode), 32'd0);
        check({tag, "_dvalue"}, 32'(disp_value), 32'd0);
        check({tag, "_dfound"}, 32'(disp_found), 32'd0);
    endtask

    initial begin
        int bc0, bs0, busy_cycles;

        // Reset state
        @(negedge clk);
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
        check("reset_no_req", 32'(busy), 32'd0);

        // Long press, bit count of 8'b10101100, start latency
        bc_starts = 0; bs_starts = 0;
        mode = 1'b0; operand = 8'b1010_1100; eng_lat = 10;
        push(8'h04, 1'b0, 1'b0);
        start_n = 1'b0;
        step(); check("lat_e1", 32'(bc_start), 32'd0);
        step(); check("lat_e2", 32'(bc_start), 32'd0);
        step(); check("lat_e3", 32'(bc_start), 32'd1);
        check("lat_e3_busy", 32'(busy), 32'd1);
        check("lat_e3_data", 32'(bc_data), 32'hAC);
        step(); check("lat_e4", 32'(bc_start), 32'd0);
        repeat (6) step();
        check("busy_in_wait", 32'(busy), 32'd1);
        check("no_valid_early", 32'(result_valid), 32'd0);
        repeat (10) step();
        start_n = 1'b1;
        repeat (3) step();
        check("one_bc_start", 32'(bc_starts), 32'd1);
        check("no_bs_start", 32'(bs_starts), 32'd0);
        wait_result("bitcount");
        check("busy_after_done", 32'(busy), 32'd0);

        // Binary search, found and not found
        mode = 1'b1; operand = 8'd10; eng_lat = 8; found_cfg = 1'b1;
        push(8'h0A, 1'b1, 1'b1);
        press();
        check("search_rvalid_cleared", 32'(result_valid), 32'd0);
        wait_result("search_found");
        found_cfg = 1'b0; operand = 8'd23;
        push(8'h00, 1'b0, 1'b1);
        press();
        wait_result("search_miss");

        // Press and mode toggle during WAIT are dropped
        bc0 = bc_starts; bs0 = bs_starts;
        mode = 1'b0; operand = 8'hFF; eng_lat = 30;
        push(8'h08, 1'b0, 1'b0);
        press();
        step(); step();
        mode = 1'b1; operand = 8'h01;
        press();
        wait_result("drop_second");
        check("drop_bc_starts", 32'(bc_starts - bc0), 32'd1);
        check("drop_bs_starts", 32'(bs_starts - bs0), 32'd0);

        // Engine never finishes
        hang = 1'b1; mode = 1'b0; operand = 8'hF0;
        start_n = 1'b0;
        busy_cycles = 0;
`ifdef TASK_SEQ_TIMEOUT_EN
        for (int i = 0; i < 100; i++) begin
            step();
            if (i == 2) start_n = 1'b1;
            if (busy) busy_cycles++;
            if (timeout_err) break;
        end
        start_n = 1'b1;
        check("wdog_terr", 32'(timeout_err), 32'd1);
        check("wdog_cycles", 32'(busy_cycles), 32'(TIMEOUT + 1));
        check("wdog_disp", 32'(disp_value), 32'hEE);
        check("wdog_found", 32'(disp_found), 32'd0);
        check("wdog_busy", 32'(busy), 32'd0);
        hang = 1'b0; eng_lat = 5; operand = 8'h0F;
        push(8'h04, 1'b0, 1'b0);
        press();
        check("err_cleared", 32'(timeout_err), 32'd0);
        wait_result("recover");
        hang = 1'b1; mode = 1'b1; operand = 8'h3C;
        press();
`else
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 2) start_n = 1'b1;
            if (busy) busy_cycles++;
        end
        start_n = 1'b1;
        check("nowdog_busy", 32'(busy), 32'd1);
        check("nowdog_terr", 32'(timeout_err), 32'd0);
        check("nowdog_cycles", 32'(busy_cycles), 32'd38);
`endif

        // Reset in WAIT, then a stray done
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        check_all_zero("midreset");
        reset = 1'b0;
        hang = 1'b0;
        force_done = 1'b1;
        repeat (3) step();
        force_done = 1'b0;
        check("stray_done_rvalid", 32'(result_valid), 32'd0);
        check("stray_done_busy", 32'(busy), 32'd0);
        check("stray_done_dvalue", 32'(disp_value), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/task_sequencer.md
# task_sequencer

Control block for lab 4. It takes the raw start key, the mode switch and the operand switches, and launches exactly one of the two datapath engines per request: the bit counter (mode 0) or the RAM binary search (mode 1). It runs the selected engine's start/done handshake, guards it with a watchdog, and captures its results. It then presents one stable, muxed result to the HEX and LEDR drivers in the top level.

## Interface
Parameters:
- DATA_W, 8, operand / search-target width
- ADDR_W, 5, binary-search RAM address width
- TIMEOUT, 1023, max cycles in WAIT before error (watchdog builds only)

Ports:
- clk  in  1  system clock (CLOCK_50 at top)
- reset  in  1  synchronous, active-high (driven from inverted KEY[0] at top)
- start_n  in  1  raw active-low start key (KEY[3]), asynchronous to clk
- mode  in  1  engine select (SW[9]): 0 = bit counter, 1 = binary search
- operand  in  DATA_W  bit-count input or search target (SW[7:0])
- bc_start  out  1  one-cycle start pulse to bit counter
- bc_data  out  DATA_W  latched operand to bit counter
- bc_done  in  1  bit counter done (level)
- bc_result  in  4  ones count, 0..8
- bs_start  out  1  one-cycle start pulse to binary search
- bs_target  out  DATA_W  latched search target
- bs_done  in  1  search done (level)
- bs_found  in  1  target found
- bs_addr  in  ADDR_W  address of the match
- busy  out  1  high in LAUNCH and WAIT
- result_valid  out  1  high in HOLD
- timeout_err  out  1  high in ERR
- disp_mode  out  1  latched mode of the last request
- disp_value  out  8  value for the HEX decoder
- disp_found  out  1  LEDR[9] found indicator

## Operation
- Start request: start_n passes through a 2-flop synchronizer plus a registered copy. req = prev & ~sync, i.e. a falling edge of the key. Each press produces one request, however long the key is held.
- FSM states: IDLE, LAUNCH, WAIT, HOLD, ERR.
- IDLE --req--> LAUNCH. On this edge mode is latched into disp_mode and operand into bc_data / bs_target.
- LAUNCH: assert the selected engine's start for one cycle, clear the watchdog, then go to WAIT unconditionally.
- WAIT:
  - Selected done high → capture results, go to HOLD.
  - Watchdog count == TIMEOUT-1 with done low → ERR.
  - If done and the terminal count occur in the same cycle, done wins.
  - done from the non-selected engine is ignored.
- HOLD --req--> LAUNCH. Operands are relatched and result_valid clears on that edge.
- ERR --req--> LAUNCH. timeout_err clears on that edge.
- req in LAUNCH or WAIT is dropped, not queued. mode and operand changes outside a req edge have no effect.
- Captured results and display mapping:
  - Mode 0: disp_value = {4'b0, bc_result}, disp_found = 0.
  - Mode 1: disp_value = bs_found ? zero-extended bs_addr : 0, disp_found = bs_found.
  - In ERR: disp_value = 8'hEE, disp_found = 0.
  - In IDLE, LAUNCH and WAIT, disp_value and disp_found hold their previous values.

## Timing
- Reset values:
  - FSM = IDLE.
  - Synchronizer and prev flops reset to 1 (key released), so reset never creates a spurious req.
  - All outputs 0, including bc_data, bs_target, disp_value, disp_mode and the watchdog.
- Start latency: let edge 1 be the first clk edge that samples start_n low. req is high after edge 2, the state enters LAUNCH at edge 3, and the engine start pulse is high for the cycle between edges 3 and 4.
- Done latency: results are captured on the edge that samples done high, and result_valid is high from the next cycle.
- Watchdog: counts WAIT cycles. ERR is entered on the TIMEOUT-th WAIT cycle without done.
- Reset asserted mid-operation: next state is IDLE, both start outputs go low and the captured results clear. The engines are reset by the same reset net.

## Configuration
- TASK_SEQ_TIMEOUT_EN defined: watchdog counter, ERR state and timeout_err are built as described above.
- TASK_SEQ_TIMEOUT_EN undefined: no counter and no ERR state. WAIT exits only on done, and timeout_err is tied 0. The TIMEOUT parameter is accepted but unused.

## Structure
- lab4_pkg holds:
  - the seq_state_t enum (IDLE, LAUNCH, WAIT, HOLD, ERR);
  - the mode_t enum (MODE_BITCOUNT = 0, MODE_SEARCH = 1);
  - DATA_W / ADDR_W defaults;
  - the ERR display constant 8'hEE.
- Sub-module key_sync_edge: the 2-flop synchronizer, prev flop and falling-edge pulse. It is reusable for KEY[0] debouncing at top.

## Test plan
Engines are behavioural models in the bench.
- Reset, then hold start_n low 20 cycles → exactly one req. bc_start is one cycle, at edge 3 after the first low sample. busy stays high until done.
- mode=0, operand=8'b10101100, model returns bc_result=4 after 10 cycles → result_valid=1, disp_value=8'h04, disp_found=0, bs_start never pulses.
- mode=1, operand=8'd10, model returns found=1, addr=5'd10 → disp_value=8'h0A, disp_found=1, disp_mode=1. With found=0 → disp_value=0, disp_found=0.
- Second press during WAIT, plus a toggle of mode mid-WAIT → no second start pulse, latched mode unchanged, one result captured.
- Build with TASK_SEQ_TIMEOUT_EN and TIMEOUT=16, model never sets done → timeout_err=1 after 16 WAIT cycles, disp_value=8'hEE. Next press clears the error and relaunches. Build without the macro → busy stays high and timeout_err stays 0.
- Assert reset in WAIT → next cycle IDLE, all outputs 0. A done arriving afterward is ignored.
